// File: rtl/move_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | move_arbiter_if: request, result and FSM-move signals of the arbiter  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface move_arbiter_if;
  logic       loc_valid;
  logic [7:0] loc_move;
  logic       loc_ready;
  logic       rem_valid;
  logic [7:0] rem_move;
  logic       rem_ready;
  logic [7:0] move;
  logic       move_avail;
  logic       res_valid;
  logic       res_src;
  logic [1:0] res_code;

  modport master (
    input  loc_valid, loc_move, rem_valid, rem_move,
    output loc_ready, rem_ready, move, move_avail, res_valid, res_src, res_code
  );

  modport slave (
    output loc_valid, loc_move, rem_valid, rem_move,
    input  loc_ready, rem_ready, move, move_avail, res_valid, res_src, res_code
  );
endinterface
`default_nettype wire

// File: rtl/move_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | move_arbiter: shares the game FSM move input between local and remote |
// | requesters, range-checks moves and reports per-source outcomes.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module move_arbiter #(
  parameter int RESULT_TIMEOUT = 64,
  parameter int BOARD_DIM      = 9
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       my_color,
  input  logic       turn,
  input  logic [5:0] fsm_state,
  input  logic       invalid_move,
  input  logic       game_over,
  output logic       busy,
  move_arbiter_if.master bus
);

  localparam int         c_tw   = (RESULT_TIMEOUT > 2) ? $clog2(RESULT_TIMEOUT) : 1;
  localparam logic [c_tw-1:0] c_tmax = c_tw'(RESULT_TIMEOUT - 1);
  localparam logic [4:0] c_dim  = 5'(BOARD_DIM);

  localparam logic [5:0] c_fsm_waiting  = 6'b000001;
  localparam logic [5:0] c_fsm_update   = 6'b000010;
  localparam logic [5:0] c_fsm_pass     = 6'b001000;
  localparam logic [5:0] c_fsm_pwaiting = 6'b010000;
  localparam logic [5:0] c_fsm_over     = 6'b100000;

  localparam logic [1:0] c_res_ok    = 2'b00;
  localparam logic [1:0] c_res_rej   = 2'b01;
  localparam logic [1:0] c_res_range = 2'b10;
  localparam logic [1:0] c_res_tmo   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_AWAIT  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  state_t          r_state, w_state_next;
  logic [7:0]      r_move;
  logic            r_src;
  logic [c_tw-1:0] r_timer;
  logic            r_res_pend;
  logic [1:0]      r_res_code_p;
  logic            r_res_src_p;

  logic       w_owner_loc, w_waiting, w_accept_st;
  logic       w_loc_ready, w_rem_ready, w_move_avail;
  logic       w_latch, w_latch_src;
  logic [7:0] w_latch_move;
  logic       w_pend_set, w_pend_src;
  logic [1:0] w_pend_code;
  logic       w_aw_res;
  logic [1:0] w_aw_code;

  // Pass (8'hFF) is always legal; anything else needs row and col on the board.
  function automatic logic f_out_of_range(input logic [7:0] m);
    return (m != 8'hFF) &&
           (({1'b0, m[7:4]} >= c_dim) || ({1'b0, m[3:0]} >= c_dim));
  endfunction

  assign w_owner_loc = (turn == my_color);
  assign w_waiting   = (fsm_state == c_fsm_waiting) || (fsm_state == c_fsm_pwaiting);
  assign w_accept_st = (fsm_state == c_fsm_update) || (fsm_state == c_fsm_pass) ||
                       (fsm_state == c_fsm_over);

  always_comb begin
    w_state_next = r_state;
    w_loc_ready  = 1'b0;
    w_rem_ready  = 1'b0;
    w_move_avail = 1'b0;
    w_latch      = 1'b0;
    w_latch_src  = 1'b0;
    w_latch_move = bus.loc_move;
    w_pend_set   = 1'b0;
    w_pend_src   = 1'b0;
    w_pend_code  = c_res_ok;
    w_aw_res     = 1'b0;
    w_aw_code    = c_res_ok;
    case (r_state)
      ST_IDLE: begin
        if (game_over) begin
          w_state_next = ST_OVER;
        end else if (w_owner_loc) begin
          if (w_waiting && bus.loc_valid) begin
            w_loc_ready  = 1'b1;
            w_latch      = 1'b1;
            w_latch_move = bus.loc_move;
            if (f_out_of_range(bus.loc_move)) begin
              w_pend_set  = 1'b1;
              w_pend_code = c_res_range;
            end else begin
              w_state_next = ST_ISSUE;
            end
          end else if (bus.rem_valid && !bus.loc_valid) begin
            // Remote tried to move out of turn: consume and reject it.
            w_rem_ready = 1'b1;
            w_pend_set  = 1'b1;
            w_pend_src  = 1'b1;
            w_pend_code = c_res_rej;
          end
        end else if (w_waiting && bus.rem_valid) begin
          w_rem_ready  = 1'b1;
          w_latch      = 1'b1;
          w_latch_src  = 1'b1;
          w_latch_move = bus.rem_move;
          if (f_out_of_range(bus.rem_move)) begin
            w_pend_set  = 1'b1;
            w_pend_src  = 1'b1;
            w_pend_code = c_res_range;
          end else begin
            w_state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        w_move_avail = 1'b1;
        w_state_next = game_over ? ST_OVER : ST_AWAIT;
      end
      ST_AWAIT: begin
        if (invalid_move) begin
          w_aw_res     = 1'b1;
          w_aw_code    = c_res_rej;
          w_state_next = game_over ? ST_OVER : ST_IDLE;
        end else if (w_accept_st || game_over) begin
          w_aw_res     = 1'b1;
          w_aw_code    = c_res_ok;
          w_state_next = game_over ? ST_OVER : ST_SETTLE;
        end else if (r_timer == c_tmax) begin
          w_aw_res     = 1'b1;
          w_aw_code    = c_res_tmo;
          w_state_next = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (game_over)      w_state_next = ST_OVER;
        else if (w_waiting) w_state_next = ST_IDLE;
      end
      ST_OVER: begin
        w_state_next = ST_OVER;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_move       <= 8'h00;
      r_src        <= 1'b0;
      r_timer      <= '0;
      r_res_pend   <= 1'b0;
      r_res_code_p <= c_res_ok;
      r_res_src_p  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_res_pend   <= w_pend_set;
      r_res_code_p <= w_pend_code;
      r_res_src_p  <= w_pend_src;
      if (w_latch) begin
        r_move <= w_latch_move;
        r_src  <= w_latch_src;
      end
      if (r_state == ST_ISSUE)      r_timer <= '0;
      else if (r_state == ST_AWAIT) r_timer <= r_timer + c_tw'(1);
    end
  end

  // Ready strobes are combinational, so they are masked while reset is held.
  assign bus.loc_ready  = w_loc_ready && !reset;
  assign bus.rem_ready  = w_rem_ready && !reset;
  assign bus.move       = r_move;
  assign bus.move_avail = w_move_avail;
  assign bus.res_valid  = w_aw_res | r_res_pend;
  assign bus.res_code   = w_aw_res ? w_aw_code : r_res_code_p;
  assign bus.res_src    = w_aw_res ? r_src : r_res_src_p;
  assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_move_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_move_arbiter: directed and randomized attempts against a          |
// | transaction-level outcome model. Revision: 1.0                        |
// +----------------------------------------------------------------------+
module tb_move_arbiter;
  localparam int TMO = 64;
  localparam int DIM = 9;
  localparam logic [5:0] WAITING    = 6'b000001;
  localparam logic [5:0] UPDATE_BUS = 6'b000010;
  localparam logic [5:0] PASS       = 6'b001000;
  localparam logic [5:0] GAME_OVER  = 6'b100000;
  localparam int R_ACC = 0, R_REJ = 1, R_NONE = 2;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       my_color, turn, invalid_move, game_over, busy;
  logic [5:0] fsm_state;
  int         n_checks = 0;
  int         n_fail   = 0;

  move_arbiter_if bus ();

  move_arbiter #(.RESULT_TIMEOUT(TMO), .BOARD_DIM(DIM)) dut (
    .clk_in(clk_in), .reset(reset), .my_color(my_color), .turn(turn),
    .fsm_state(fsm_state), .invalid_move(invalid_move), .game_over(game_over),
    .busy(busy), .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_in);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".loc_ready"}, 32'(bus.loc_ready), 0);
    chk({tag, ".rem_ready"}, 32'(bus.rem_ready), 0);
    chk({tag, ".move_avail"}, 32'(bus.move_avail), 0);
    chk({tag, ".res_valid"}, 32'(bus.res_valid), 0);
  endtask

  function automatic logic oor(input logic [7:0] m);
    int row, col;
    row = int'(m[7:4]);
    col = int'(m[3:0]);
    return (m != 8'hFF) && (row >= DIM || col >= DIM);
  endfunction

  // One complete attempt from an idle arbiter; expectations come from the
  // ownership / range / response rules evaluated per transaction.
  task automatic attempt(input logic t, input logic c, input logic lv, input logic [7:0] lm,
                         input logic rv, input logic [7:0] rm, input int resp, input int d);
    logic       own_loc, served, rem_rej, src;
    logic [7:0] m;
    int         res_at;
    logic [1:0] code;
    own_loc = (t == c);
    served  = own_loc ? lv : rv;
    rem_rej = own_loc && !lv && rv;
    src     = !own_loc;
    m       = own_loc ? lm : rm;

    step();
    turn = t; my_color = c; fsm_state = WAITING; game_over = 0; invalid_move = 0;
    bus.loc_valid = lv; bus.loc_move = lm; bus.rem_valid = rv; bus.rem_move = rm;
    mid();
    chk("req.loc_ready", 32'(bus.loc_ready), 32'(own_loc && lv));
    chk("req.rem_ready", 32'(bus.rem_ready), 32'(own_loc ? (!lv && rv) : rv));
    chk("req.move_avail", 32'(bus.move_avail), 0);

    step();
    bus.loc_valid = 0; bus.rem_valid = 0;
    mid();
    if (!served && !rem_rej) begin
      chk("none.res_valid", 32'(bus.res_valid), 0);
      chk("none.busy", 32'(busy), 0);
      return;
    end
    if (rem_rej) begin
      chk("nonowner.res_valid", 32'(bus.res_valid), 1);
      chk("nonowner.res_src", 32'(bus.res_src), 1);
      chk("nonowner.res_code", 32'(bus.res_code), 1);
      chk("nonowner.move_avail", 32'(bus.move_avail), 0);
      return;
    end
    if (oor(m)) begin
      chk("range.res_valid", 32'(bus.res_valid), 1);
      chk("range.res_src", 32'(bus.res_src), 32'(src));
      chk("range.res_code", 32'(bus.res_code), 2);
      chk("range.move_avail", 32'(bus.move_avail), 0);
      step(); mid();
      chk("range.after_res", 32'(bus.res_valid), 0);
      chk("range.busy", 32'(busy), 0);
      return;
    end
    chk("issue.move_avail", 32'(bus.move_avail), 1);
    chk("issue.move", 32'(bus.move), 32'(m));
    chk("issue.res_valid", 32'(bus.res_valid), 0);

    res_at = (resp == R_NONE) ? TMO : d;
    code   = (resp == R_ACC) ? 2'b00 : (resp == R_REJ) ? 2'b01 : 2'b11;
    for (int k = 1; k <= res_at; k++) begin
      step();
      if (k == res_at && resp == R_ACC) fsm_state = (m == 8'hFF) ? PASS : UPDATE_BUS;
      if (k == res_at && resp == R_REJ) invalid_move = 1;
      mid();
      if (k < res_at) begin
        if (k == 1 || k == res_at - 1) begin
          chk("await.res_valid", 32'(bus.res_valid), 0);
          chk("await.move_avail", 32'(bus.move_avail), 0);
          chk("await.move", 32'(bus.move), 32'(m));
        end
      end else begin
        chk("result.res_valid", 32'(bus.res_valid), 1);
        chk("result.res_code", 32'(bus.res_code), 32'(code));
        chk("result.res_src", 32'(bus.res_src), 32'(src));
      end
    end

    step();
    invalid_move = 0;
    mid();
    chk("post.res_valid", 32'(bus.res_valid), 0);
    if (resp == R_ACC) begin
      chk("settle.busy", 32'(busy), 1);
      step(); mid();
      chk("settle.move_avail", 32'(bus.move_avail), 0);
      step();
      fsm_state = WAITING;
      turn = ~turn;
      mid();
      chk("settle.last_busy", 32'(busy), 1);
      step(); mid();
    end
    chk("post.busy", 32'(busy), 0);
  endtask

  initial begin
    reset = 1; my_color = 0; turn = 0; fsm_state = WAITING; invalid_move = 0; game_over = 0;
    bus.loc_valid = 0; bus.loc_move = 8'h00; bus.rem_valid = 0; bus.rem_move = 8'h00;
    step(); step();
    mid();
    chk("reset.busy", 32'(busy), 0);
    chk("reset.move", 32'(bus.move), 0);
    chk("reset.res_code", 32'(bus.res_code), 0);
    chk_quiet("reset");
    step();
    reset = 0;

    // Directed steps
    attempt(0, 0, 1, 8'h34, 0, 8'h00, R_ACC, 2);
    attempt(0, 0, 1, 8'h34, 0, 8'h00, R_REJ, 1);
    attempt(0, 0, 1, 8'h21, 0, 8'h00, R_ACC, 1);
    attempt(0, 0, 1, 8'h92, 0, 8'h00, R_ACC, 1);
    attempt(0, 0, 1, 8'h29, 0, 8'h00, R_ACC, 1);
    attempt(1, 0, 1, 8'h55, 1, 8'h00, R_ACC, 1);
    attempt(0, 0, 0, 8'h00, 1, 8'h12, R_ACC, 1);
    attempt(1, 1, 1, 8'hFF, 0, 8'h00, R_ACC, 3);
    attempt(0, 0, 1, 8'h88, 0, 8'h00, R_NONE, 0);
    attempt(0, 0, 1, 8'h10, 0, 8'h00, R_ACC, TMO);

    // Randomized attempts
    for (int i = 0; i < 40; i++) begin
      logic [7:0] lm, rm;
      int sel;
      sel = $urandom_range(3);
      lm  = (sel == 0) ? 8'hFF : (sel == 3) ? 8'($urandom) :
            {4'($urandom_range(DIM - 1)), 4'($urandom_range(DIM - 1))};
      sel = $urandom_range(3);
      rm  = (sel == 0) ? 8'hFF : (sel == 3) ? 8'($urandom) :
            {4'($urandom_range(DIM - 1)), 4'($urandom_range(DIM - 1))};
      attempt(1'($urandom), 1'($urandom), 1'($urandom_range(3) != 0), lm,
              1'($urandom), rm, int'($urandom_range(1)), int'($urandom_range(6, 1)));
    end

    // Asynchronous reset in the middle of an attempt
    step();
    turn = 0; my_color = 0; fsm_state = WAITING; bus.loc_valid = 1; bus.loc_move = 8'h45;
    mid();
    chk("rst_att.loc_ready", 32'(bus.loc_ready), 1);
    step();
    bus.loc_valid = 0;
    mid();
    chk("rst_att.move_avail", 32'(bus.move_avail), 1);
    step(); step();
    mid();
    chk("rst_att.busy", 32'(busy), 1);
    #2;
    reset = 1;
    bus.loc_valid = 1;
    #1;
    chk("async_rst.busy", 32'(busy), 0);
    chk("async_rst.move", 32'(bus.move), 0);
    chk_quiet("async_rst");
    step();
    reset = 0;
    bus.loc_valid = 0;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("post_rst.res_valid", 32'(bus.res_valid), 0);
      chk("post_rst.busy", 32'(busy), 0);
      step();
    end

    // game_over while awaiting the outcome
    turn = 1; my_color = 1; bus.loc_valid = 1; bus.loc_move = 8'h07;
    mid();
    chk("go.loc_ready", 32'(bus.loc_ready), 1);
    step();
    bus.loc_valid = 0;
    mid();
    chk("go.move_avail", 32'(bus.move_avail), 1);
    step();
    fsm_state = GAME_OVER; game_over = 1;
    mid();
    chk("go.res_valid", 32'(bus.res_valid), 1);
    chk("go.res_code", 32'(bus.res_code), 0);
    step();
    fsm_state = WAITING; bus.loc_valid = 1;
    mid();
    chk("over.busy", 32'(busy), 1);
    chk_quiet("over");
    step(); step();
    mid();
    chk("over.hold_busy", 32'(busy), 1);
    chk("over.hold_ready", 32'(bus.loc_ready), 0);
    bus.loc_valid = 0;
    reset = 1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/move_arbiter.md
Name: move_arbiter

Overview:
- Shares the game FSM's single move input (move, move_avail) between two requesters: the local player input path and the remote link receive path.
- Selects the legal requester from turn and my_color, range-checks moves, and issues exactly one start pulse per attempt.
- Tracks the FSM's accept or reject outcome, with a timeout, and returns a per-source result handshake.
- Sits between the keypad/UART-rx front ends and the game FSM / board updater.

Parameters:
- RESULT_TIMEOUT, 64: cycles to wait for an outcome after a start pulse before declaring a timeout.
- BOARD_DIM, 9: legal row/column count; coordinates 0..BOARD_DIM-1.

Ports:
- clk_in  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- my_color  in  1  colour played locally (0 black, 1 white)
- turn  in  1  side to move, from the game FSM
- fsm_state  in  6  one-hot game FSM state (WAITING 000001, UPDATE_BUS 000010, SENDING_MOVE 000100, PASS 001000, PASSED_WAITING 010000, GAME_OVER 100000)
- invalid_move  in  1  board updater reject pulse
- game_over  in  1  game FSM terminal flag
- loc_valid  in  1  local move request, held until loc_ready
- loc_move  in  8  local move, row[7:4] col[3:0], 8'hFF = pass
- loc_ready  out  1  one-cycle pulse: local request consumed
- rem_valid  in  1  remote move request, held until rem_ready
- rem_move  in  8  remote move, same encoding as loc_move
- rem_ready  out  1  one-cycle pulse: remote request consumed
- move  out  8  move presented to the game FSM
- move_avail  out  1  one-cycle start pulse to the FSM
- res_valid  out  1  one-cycle result pulse
- res_src  out  1  source of the result (0 local, 1 remote)
- res_code  out  2  00 accepted, 01 rejected by rules, 10 out of range, 11 timeout
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, effective immediately): state IDLE; all outputs 0; move = 8'h00; timer cleared. Reset mid-attempt abandons the attempt silently, with no res_valid.
- Owner: local when turn == my_color, otherwise remote. Only the owner's request is examined.
- Non-owner handling: a local request is held off (loc_ready stays 0). A remote request is consumed with rem_ready and produces res_valid with res_src = 1 and res_code = 01; no issue occurs.
- IDLE:
  - Requires fsm_state to be WAITING or PASSED_WAITING and the owner's valid to be high.
  - The same cycle pulses that source's ready and latches the move.
  - Out-of-range move (not 8'hFF, and row or col >= BOARD_DIM): next cycle res_valid with code 10; stay IDLE.
  - Otherwise go to ISSUE.
  - If both valids are high, only the owner is served that cycle.
- ISSUE (1 cycle): move_avail = 1, move = latched value; timer cleared; go to AWAIT.
- AWAIT:
  - move stays stable; timer increments each cycle.
  - invalid_move: res_valid with code 01, go to IDLE.
  - Else fsm_state is UPDATE_BUS, PASS or GAME_OVER: res_valid with code 00, go to SETTLE.
  - Else timer == RESULT_TIMEOUT-1: res_valid with code 11, go to IDLE.
  - If invalid_move and an accept state occur in the same cycle, invalid_move wins.
- SETTLE:
  - Waits until fsm_state returns to WAITING or PASSED_WAITING, so turn has flipped, then goes to IDLE.
  - If game_over, goes to OVER instead.
  - No request is consumed while in SETTLE.
- OVER: absorbing until reset; ready outputs held 0; busy = 1.
- Global: game_over from any state forces OVER next cycle. If an outcome is pending in AWAIT, it reports res_valid with code 00 first.
- Pass handling: 8'hFF is always in range and issued normally. Double-pass termination is decided by the FSM.
- Latency: request accepted at cycle N, move_avail at N+1. Earliest result is N+2.
- Ready and result pulses are exactly one cycle wide. res_src always reflects the latched source.

Test Plan:
- turn = 0, my_color = 0, loc_move = 8'h34 held; FSM goes WAITING -> UPDATE_BUS two cycles after move_avail -> loc_ready at N, move_avail at N+1 with move = 34, then res_valid with src 0, code 00; no new issue until fsm_state returns to WAITING.
- Same setup, invalid_move pulsed one cycle after move_avail -> res_valid code 01; back in IDLE; the next loc_valid is accepted.
- loc_move = 8'h92 (row 9) -> loc_ready, then res_valid code 10; move_avail never asserted.
- turn = 1, my_color = 0, loc_valid and rem_valid (8'h00) both high -> remote served, move_avail with move 00; loc_ready stays 0.
- turn = 0, my_color = 0, rem_valid high -> rem_ready, then res_valid src 1, code 01; no move_avail.
- Issue with no FSM response for RESULT_TIMEOUT cycles -> res_valid code 11 exactly at timeout. Separately: reset asserted asynchronously during AWAIT -> all outputs 0 immediately, with no result.
